signed_mac_acc: RTL and testbench

Accumulator stage sitting directly downstream of the signed integer multiplier. It consumes a stream of `2*WIDTH`-bit signed products over a valid/ready handshake and sums each group of `LEN` consecutive products into one signed dot-product result. It presents that result on a registered output handshake together with a sticky overflow flag. It normalises the multiplier's "negative zero" encoding and supports wrap or saturating arithmetic.

---
 rtl/signed_mac_acc.sv | 96 +++++++++
 tb/tb_signed_mac_acc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_mac_acc.sv
// Signed dot-product accumulator behind the integer multiplier: sums LEN products per
// result, folds the multiplier's negative-zero code to 0, and wraps or saturates on overflow.
module signed_mac_acc #(
    parameter int WIDTH     = 8,
    parameter int LEN       = 16,
    parameter int ACC_WIDTH = 20,
    parameter int SAT       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [2*WIDTH-1:0]     prod,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_ovf,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(LEN - 1);
    localparam logic [PW-1:0]        NEG_ZERO = {1'b1, {(PW-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 ovf_run;

    logic                 accept;
    logic                 last;
    logic [PW-1:0]        prod_norm;
    logic [ACC_WIDTH:0]   sum;
    logic                 add_ovf;
    logic [ACC_WIDTH-1:0] sum_fit;

    assign prod_ready = ~out_valid | out_ready;
    assign accept     = prod_valid & prod_ready;
    assign last       = (cnt == CNT_LAST);
    assign prod_norm  = (prod == NEG_ZERO) ? '0 : prod;

    // One guard bit above the accumulator exposes signed overflow as a sign-bit disagreement.
    assign sum     = {acc[ACC_WIDTH-1], acc}
                   + {{(ACC_WIDTH+1-PW){prod_norm[PW-1]}}, prod_norm};
    assign add_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    always_comb begin
        sum_fit = sum[ACC_WIDTH-1:0];
        if (SAT != 0 && add_ovf) begin
            sum_fit = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf_run   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                state     <= ACCUM;
                out_valid <= 1'b0;
            end
            // A completing accept below overrides the handshake release, keeping LEN=1 gapless.
            if (clear) begin
                acc     <= '0;
                cnt     <= '0;
                ovf_run <= 1'b0;
            end else if (accept) begin
                if (last) begin
                    acc_out   <= sum_fit;
                    acc_ovf   <= ovf_run | add_ovf;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf_run   <= 1'b0;
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end else begin
                    acc     <= sum_fit;
                    cnt     <= cnt + CW'(1);
                    ovf_run <= ovf_run | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_mac_acc.sv
// Directed bench for signed_mac_acc: four parameterisations share stimulus wires, and a
// reference model pushes expected results to a scoreboard that is drained on each output handshake.
module tb_signed_mac_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] prod = '0;
    logic [3:0]  pv = '0;

    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic        val_a, val_b, val_c, val_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic [17:0] acc_a, acc_d;
    logic [15:0] acc_b, acc_c;

    always #5 clk = ~clk;

    signed_mac_acc #(.WIDTH(8), .LEN(4), .ACC_WIDTH(18), .SAT(0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_valid(pv[0]),
        .prod_ready(rdy_a), .acc_out(acc_a), .acc_ovf(ovf_a), .out_valid(val_a),
        .out_ready(out_ready));
    signed_mac_acc #(.WIDTH(8), .LEN(4), .ACC_WIDTH(16), .SAT(0)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_valid(pv[1]),
        .prod_ready(rdy_b), .acc_out(acc_b), .acc_ovf(ovf_b), .out_valid(val_b),
        .out_ready(out_ready));
    signed_mac_acc #(.WIDTH(8), .LEN(4), .ACC_WIDTH(16), .SAT(1)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_valid(pv[2]),
        .prod_ready(rdy_c), .acc_out(acc_c), .acc_ovf(ovf_c), .out_valid(val_c),
        .out_ready(out_ready));
    signed_mac_acc #(.WIDTH(8), .LEN(1), .ACC_WIDTH(18), .SAT(0)) dut_d (
        .clk(clk), .rst(rst), .clear(clear), .prod(prod), .prod_valid(pv[3]),
        .prod_ready(rdy_d), .acc_out(acc_d), .acc_ovf(ovf_d), .out_valid(val_d),
        .out_ready(out_ready));

    int                 sel = 0;
    logic signed [31:0] obs_acc;
    logic               obs_ovf, obs_valid, obs_ready;

    always_comb begin
        obs_acc = $signed(acc_a);
        obs_ovf = ovf_a; obs_valid = val_a; obs_ready = rdy_a;
        case (sel)
            1: begin obs_acc = $signed(acc_b); obs_ovf = ovf_b; obs_valid = val_b; obs_ready = rdy_b; end
            2: begin obs_acc = $signed(acc_c); obs_ovf = ovf_c; obs_valid = val_c; obs_ready = rdy_c; end
            3: begin obs_acc = $signed(acc_d); obs_ovf = ovf_d; obs_valid = val_d; obs_ready = rdy_d; end
            default: ;
        endcase
    end

    typedef struct {
        logic signed [31:0] acc;
        logic               ovf;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     m_len, m_accw, m_sat, m_cnt;
    longint m_acc;
    logic   m_ovf, m_hold;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        sb.delete();
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
    endtask

    // Right after reset: everything zero and the stage ready.
    task automatic checkResetOutputs();
        @(negedge clk);
        rst = 1'b0; pv = '0; clear = 1'b0;
        #1;
        checkOutput("rst_acc_out", obs_acc, 0);
        checkOutput("rst_acc_ovf", obs_ovf, 0);
        checkOutput("rst_out_valid", obs_valid, 0);
        checkOutput("rst_prod_ready", obs_ready, 1);
    endtask

    task automatic selectDut(input int s, input int len, input int accw, input int sat);
        @(negedge clk);
        sel = s; m_len = len; m_accw = accw; m_sat = sat;
        rst = 1'b1; pv = '0; clear = 1'b0;
        @(posedge clk);
        modelReset();
        checkResetOutputs();
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic applyStimulus(input logic v, input logic [15:0] p, input logic ordy,
                                 input logic clr, input logic rs);
        logic   exp_ready, done;
        longint pr, s, lim, span;
        logic   o;
        exp_t   e;
        @(negedge clk);
        prod = p; pv = v ? 4'(1 << sel) : 4'b0; out_ready = ordy; clear = clr; rst = rs;
        #1;
        exp_ready = !m_hold || ordy;
        done = 1'b0;
        checkOutput("prod_ready", obs_ready, exp_ready);
        checkOutput("out_valid", obs_valid, m_hold);
        if (m_hold && sb.size() > 0) begin
            checkOutput("acc_out", obs_acc, sb[0].acc);
            checkOutput("acc_ovf", obs_ovf, sb[0].ovf);
            if (ordy) void'(sb.pop_front());
        end
        if (rs) begin
            modelReset();
        end else begin
            if (clr) begin
                m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
            end else if (v && exp_ready) begin
                pr   = (p == 16'h8000) ? 0 : longint'($signed(p));
                s    = m_acc + pr;
                lim  = longint'(1) << (m_accw - 1);
                span = longint'(1) << m_accw;
                o    = (s >= lim) || (s < -lim);
                if (o) begin
                    if (m_sat != 0) s = (s > 0) ? lim - 1 : -lim;
                    else begin
                        s = s % span;
                        if (s >= lim) s = s - span;
                        else if (s < -lim) s = s + span;
                    end
                end
                if (m_cnt == m_len - 1) begin
                    e.acc = 32'(s);
                    e.ovf = m_ovf | o;
                    sb.push_back(e);
                    m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
                    done = 1'b1;
                end else begin
                    m_acc = s; m_cnt++; m_ovf = m_ovf | o;
                end
            end
            if (done) m_hold = 1'b1;
            else if (m_hold && ordy) m_hold = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        // Sum with negative zero
        selectDut(0, 4, 18, 0);
        applyStimulus(1, 16'd100, 1, 0, 0);
        applyStimulus(1, 16'hFFCE, 1, 0, 0);
        applyStimulus(1, 16'h8000, 1, 0, 0);
        applyStimulus(1, 16'd25, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);

        // Back-pressure with upstream holding a valid product
        applyStimulus(1, 16'hC0FF, 0, 0, 0);
        applyStimulus(1, 16'd100, 0, 0, 0);
        applyStimulus(1, 16'hFF9C, 0, 0, 0);
        applyStimulus(1, 16'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'd5, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'd5, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);

        // Clear mid-vector discards the product accepted alongside it
        applyStimulus(1, 16'd7, 1, 0, 0);
        applyStimulus(1, 16'd9, 1, 0, 0);
        applyStimulus(1, 16'd1000, 1, 1, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);

        // Reset mid-vector, then mid-HOLD
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'd5, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 1);
        checkResetOutputs();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'd5, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'd1, 0, 0, 0);
        applyStimulus(0, 16'd0, 0, 0, 0);
        applyStimulus(0, 16'd0, 0, 0, 1);
        checkResetOutputs();
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'd5, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);

        // Overflow: wrap, then saturate, each followed by a clean vector
        for (int d = 1; d <= 2; d++) begin
            selectDut(d, 4, 16, d - 1);
            for (int i = 0; i < 4; i++) applyStimulus(1, 16'd16129, 1, 0, 0);
            for (int i = 0; i < 4; i++) applyStimulus(1, 16'd1, 1, 0, 0);
            applyStimulus(0, 16'd0, 1, 0, 0);
            applyStimulus(0, 16'd0, 1, 0, 0);
        end

        // LEN=1 streaming with no bubbles
        selectDut(3, 1, 18, 0);
        applyStimulus(1, 16'd3, 1, 0, 0);
        applyStimulus(1, 16'hFFFC, 1, 0, 0);
        applyStimulus(1, 16'd5, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);
        applyStimulus(0, 16'd0, 1, 0, 0);

        checkOutput("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
